repeat_sub_divider: RTL and testbench
=====================================

REPEAT_SUB_DIVIDER -- requirements
Module: repeat_sub_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  dividend; captured on the accepted start edge.
REQ-006 SHALL have port B  input  WIDTH  divisor; captured on the accepted start edge.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse when results are valid.
REQ-009 SHALL have port quotient  output  WIDTH  floor(A/B).
REQ-010 SHALL have port remainder  output  WIDTH  A mod B.
REQ-011 SHALL have port div_zero  output  1  set when the captured B was 0.

Function
REQ-012 SHALL compute division by repeated subtraction: the inverse of an accumulate-by-addition datapath, with one subtraction per clock.
REQ-013 SHALL implement FSM states IDLE, SUB and DONE.
REQ-014 IDLE, start=1, B!=0 SHALL load rem_reg<=A, quo_reg<=0 and div_reg<=B, then go to SUB.
REQ-015 IDLE, start=1, B==0 SHALL load rem_reg<=A, quo_reg<=all-ones and div_zero<=1, then go to DONE.
REQ-016 IDLE, start=0 SHALL hold all registers.
REQ-017 SUB, rem_reg>=div_reg SHALL apply rem_reg<=rem_reg-div_reg and quo_reg<=quo_reg+1, and stay in SUB.
REQ-018 SUB, rem_reg<div_reg SHALL go to DONE with no register update.
REQ-019 DONE SHALL assert done=1 for exactly that one cycle, then go to IDLE unconditionally.
REQ-020 busy SHALL be 1 in SUB and DONE, and 0 in IDLE.
REQ-021 The subtract comparison SHALL be unsigned; subtraction SHALL never underflow, because it is guarded by REQ-017.
REQ-022 quo_reg SHALL never wrap, because the quotient is at most A, which is at most 2^WIDTH-1.
REQ-023 Latency with B!=0 SHALL be: done high in the cycle following the (q+2)th rising edge after the accepting start edge, where q=floor(A/B).
REQ-024 Latency with B==0 SHALL be: done high after the first edge following the accepting start edge.
REQ-025 start SHALL be ignored while busy=1; a start level held during DONE SHALL NOT be accepted until IDLE.
REQ-026 A and B SHALL be don't-care after capture; input changes mid-operation SHALL NOT affect the result.
REQ-027 quotient and remainder SHALL drive quo_reg and rem_reg directly.
REQ-028 quotient and remainder SHALL hold the last result in IDLE until the next accepted start.
REQ-029 quotient and remainder SHALL be valid for checking only while done=1 or in IDLE.
REQ-030 div_zero SHALL be cleared on every accepted start with B!=0 and SHALL otherwise hold.
REQ-031 A=0 with B!=0 SHALL give q=0, r=0, and done after 2 edges.

Reset
REQ-032 rst_n=0 SHALL immediately force: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, div_reg=0.
REQ-033 Reset asserted mid-division SHALL abort it with no done pulse.
REQ-034 After reset release the block SHALL wait in IDLE for a new start.
REQ-035 The first rising clk edge with rst_n=1 SHALL be able to accept start.

Verification
REQ-036 A=17, B=5, start pulse -> busy 1; done on the 5th edge; quotient=3, remainder=2, div_zero=0.
REQ-037 A=4, B=9 -> done on the 2nd edge; quotient=0, remainder=4.
REQ-038 A=255, B=1 -> done on the 257th edge; quotient=255, remainder=0; no wrap.
REQ-039 A=42, B=0 -> done on the 1st edge; div_zero=1, quotient=0xFF, remainder=42; then A=10, B=3 -> div_zero=0, quotient=3, remainder=1.
REQ-040 A=100, B=7 started, then start re-pulsed with A=9, B=2 at edge 4 -> ignored; done on the 16th edge; quotient=14, remainder=2.
REQ-041 A=200, B=3 started, then rst_n low at edge 10 -> all outputs 0 asynchronously; no done; a new start A=6, B=3 -> quotient=2, remainder=0.

Source files
------------

// File: rtl/repeat_sub_divider.sv
// Unsigned divider: one subtraction per clock until the remainder drops below the divisor.
// Ports: clk, rst_n, start, A, B in; busy, done, quotient, remainder, div_zero out.
module repeat_sub_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  // Subtraction is only taken when it cannot underflow.
  logic             can_sub;
  assign can_sub = (rem_q >= div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rem_q  <= A;
            busy_q <= 1'b1;
            if (B == '0) begin
              // No iteration: saturated quotient, dividend left as remainder.
              quo_q   <= '1;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              quo_q   <= '0;
              div_q   <= B;
              dz_q    <= 1'b0;
              state_q <= SUB;
            end
          end
        end
        SUB: begin
          if (can_sub) begin
            rem_q <= rem_q - div_q;
            quo_q <= quo_q + WIDTH'(1);
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_repeat_sub_divider.sv
// Directed bench for repeat_sub_divider.
// Drives on falling edges, checks on falling edges.
module tb_repeat_sub_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;

  int n_cmp  = 0;
  int n_fail = 0;
  int edges;

  repeat_sub_divider #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept on edge 1, then count edges until done is seen.
  task automatic wait_done;
    while (done !== 1'b1 && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er,
                     input logic edz, input int eedges);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done();
    chk({tag, ".edges"}, 32'(edges), 32'(eedges));
    chk({tag, ".quo"}, 32'(quotient), 32'(eq));
    chk({tag, ".rem"}, 32'(remainder), 32'(er));
    chk({tag, ".dz"}, 32'(div_zero), 32'(edz));
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A = 8'd0;
    B = 8'd0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.quo", 32'(quotient), 32'd0);
    chk("rst.rem", 32'(remainder), 32'd0);
    chk("rst.dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("d17_5", 8'd17, 8'd5, 8'd3, 8'd2, 1'b0, 5);
    run("d4_9", 8'd4, 8'd9, 8'd0, 8'd4, 1'b0, 2);
    run("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 257);
    run("d42_0", 8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1);
    run("d10_3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 5);
    run("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 2);

    // Start re-pulsed at edge 4 while busy must be ignored.
    @(negedge clk);
    A = 8'd100;
    B = 8'd7;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    A = 8'd9;
    B = 8'd2;
    start = 1'b1;
    @(posedge clk);
    edges++;
    @(negedge clk);
    start = 1'b0;
    chk("rep.busy", 32'(busy), 32'd1);
    wait_done();
    chk("rep.edges", 32'(edges), 32'd16);
    chk("rep.quo", 32'(quotient), 32'd14);
    chk("rep.rem", 32'(remainder), 32'd2);

    // Reset mid-division aborts without a done pulse.
    @(negedge clk);
    A = 8'd200;
    B = 8'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.quo", 32'(quotient), 32'd0);
    chk("abort.rem", 32'(remainder), 32'd0);
    chk("abort.dz", 32'(div_zero), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort.nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1;

    run("d6_3", 8'd6, 8'd3, 8'd2, 8'd0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
